// File: rtl/conv1_pkg.sv
// Shared definitions for the layer-1 convolution engine (weight ROM array,
// MAC array and the weight ROM sequencer).
//
// Contents:
//   L1_ADDR        ROM address width (ROM depth 2**L1_ADDR)
//   L1_TAPS        kernel taps per output pixel (3x3 kernel x 3 input channels)
//   L1_OUT_PIXELS  output pixels per frame (111x111)
//   L1_PIX_W       width of the output pixel counter
//   seq_state_t    sequencer FSM state encoding
package conv1_pkg;

  localparam int L1_ADDR       = 5;
  localparam int L1_TAPS       = 27;
  localparam int L1_OUT_PIXELS = 12321;
  localparam int L1_PIX_W      = 14;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_WIN = 2'd1,
    STREAM   = 2'd2,
    DONE     = 2'd3
  } seq_state_t;

endpackage

// File: rtl/weight_rom_sequencer_layer_1.sv
// Weight ROM sequencer for conv layer 1.
//
// For every output pixel of a frame the sequencer waits for the image window
// buffer to present a complete window, then streams ROM addresses 0..TAPS-1
// to the (combinational) weight ROM array and the MAC array, flags the first
// and last tap so the MACs can clear and dump their accumulators, and pops
// the window once its last tap has been accepted.
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset
//   start      frame start pulse (only honoured while idle)
//   win_valid  image buffer holds a complete input window
//   win_pop    one-cycle pulse: current window consumed
//   rom_addr   weight ROM address
//   tap_valid  rom_addr / ROM data valid for the MAC array
//   tap_ready  MAC array accepts the current tap
//   first_tap  tap_valid && rom_addr == 0
//   last_tap   tap_valid && rom_addr == TAPS-1
//   pixel_idx  index of the pixel being processed
//   busy       high in every state except IDLE
//   done       one-cycle pulse after the last tap of the last pixel
//   fsm_state  current FSM state (seq_state_t encoding), for observation
//
// Handshake: a tap transfers on every rising clk edge where tap_valid and
// tap_ready are both high. While tap_valid is high and tap_ready is low,
// rom_addr, pixel_idx and tap_valid hold their values; the sequencer never
// withdraws a tap it has offered. tap_ready has no effect while tap_valid is
// low.
module weight_rom_sequencer_layer_1
  import conv1_pkg::*;
#(
  parameter int ADDR       = L1_ADDR,
  parameter int TAPS       = L1_TAPS,
  parameter int OUT_PIXELS = L1_OUT_PIXELS,
  parameter int PIX_W      = L1_PIX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             win_valid,
  output logic             win_pop,
  output logic [ADDR-1:0]  rom_addr,
  output logic             tap_valid,
  input  logic             tap_ready,
  output logic             first_tap,
  output logic             last_tap,
  output logic [PIX_W-1:0] pixel_idx,
  output logic             busy,
  output logic             done,
  output logic [1:0]       fsm_state
);

  // Parameter sanity: the tap counter must be able to reach TAPS-1 and the
  // pixel counter must be able to reach OUT_PIXELS-1 without wrapping.
  if (TAPS < 1 || TAPS > (1 << ADDR)) begin : g_bad_taps
    $error("weight_rom_sequencer_layer_1: TAPS must be in 1..2**ADDR");
  end
  if (OUT_PIXELS < 1 || OUT_PIXELS > (1 << PIX_W)) begin : g_bad_pixels
    $error("weight_rom_sequencer_layer_1: OUT_PIXELS must be in 1..2**PIX_W");
  end

  localparam logic [ADDR-1:0]  LAST_TAP = ADDR'(TAPS - 1);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(OUT_PIXELS - 1);

  // Registered state
  seq_state_t       state_q;
  logic [ADDR-1:0]  addr_q;
  logic [PIX_W-1:0] pix_q;
  logic             tap_valid_q;
  logic             win_pop_q;
  logic             busy_q;
  logic             done_q;

  // Next-state values
  seq_state_t       state_n;
  logic [ADDR-1:0]  addr_n;
  logic [PIX_W-1:0] pix_n;
  logic             tap_valid_n;
  logic             win_pop_n;
  logic             done_n;

  logic             accept;

  assign accept = tap_valid_q && tap_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Any in-flight pixel is abandoned; no win_pop is issued for it.
      state_q     <= IDLE;
      addr_q      <= '0;
      pix_q       <= '0;
      tap_valid_q <= 1'b0;
      win_pop_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      addr_q      <= addr_n;
      pix_q       <= pix_n;
      tap_valid_q <= tap_valid_n;
      win_pop_q   <= win_pop_n;
      busy_q      <= (state_n != IDLE);
      done_q      <= done_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    addr_n      = addr_q;
    pix_n       = pix_q;
    tap_valid_n = 1'b0;
    win_pop_n   = 1'b0;
    done_n      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_n = WAIT_WIN;
          pix_n   = '0;
          addr_n  = '0;
        end
      end

      WAIT_WIN: begin
        if (win_valid) begin
          state_n     = STREAM;
          tap_valid_n = 1'b1;
          addr_n      = '0;
        end
      end

      STREAM: begin
        // The window stays latched in the image buffer until win_pop, so
        // win_valid is deliberately not looked at here.
        tap_valid_n = 1'b1;
        if (accept) begin
          if (addr_q == LAST_TAP) begin
            tap_valid_n = 1'b0;
            win_pop_n   = 1'b1;
            addr_n      = '0;
            if (pix_q == LAST_PIX) begin
              state_n = DONE;
              done_n  = 1'b1;
            end else begin
              // Always go back through WAIT_WIN: one bubble per pixel even
              // when the next window is already available.
              pix_n   = pix_q + 1'b1;
              state_n = WAIT_WIN;
            end
          end else begin
            addr_n = addr_q + 1'b1;
          end
        end
      end

      DONE: begin
        state_n = IDLE;
        pix_n   = '0;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign win_pop   = win_pop_q;
  assign rom_addr  = addr_q;
  assign tap_valid = tap_valid_q;
  assign pixel_idx = pix_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fsm_state = state_q;

  // Accumulator control decoded from registered state.
  assign first_tap = tap_valid_q && (addr_q == '0);
  assign last_tap  = tap_valid_q && (addr_q == LAST_TAP);

endmodule

// File: tb/tb_weight_rom_sequencer_layer_1.sv
module tb_weight_rom_sequencer_layer_1;
  import conv1_pkg::*;

  localparam int ADDR       = 5;
  localparam int TAPS       = 27;
  localparam int OUT_PIXELS = 2;
  localparam int PIX_W      = 14;
  localparam int EW         = PIX_W + ADDR + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             start;
  logic             win_valid;
  logic             win_pop;
  logic [ADDR-1:0]  rom_addr;
  logic             tap_valid;
  logic             tap_ready;
  logic             first_tap;
  logic             last_tap;
  logic [PIX_W-1:0] pixel_idx;
  logic             busy;
  logic             done;
  logic [1:0]       fsm_state;

  weight_rom_sequencer_layer_1 #(
    .ADDR(ADDR), .TAPS(TAPS), .OUT_PIXELS(OUT_PIXELS), .PIX_W(PIX_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .win_valid(win_valid),
    .win_pop(win_pop), .rom_addr(rom_addr), .tap_valid(tap_valid),
    .tap_ready(tap_ready), .first_tap(first_tap), .last_tap(last_tap),
    .pixel_idx(pixel_idx), .busy(busy), .done(done), .fsm_state(fsm_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- scoreboard ----------------
  // Entry: {pixel_idx, rom_addr, first_tap, last_tap} of each expected accept.
  logic [EW-1:0] exp_q[$];
  int n_acc   = 0;
  int n_first = 0;
  int n_last  = 0;
  int n_pop   = 0;

  always @(negedge clk) begin
    logic [EW-1:0] got;
    logic [EW-1:0] exp_e;
    if (rst_n && tap_valid && tap_ready) begin
      n_acc++;
      if (first_tap) n_first++;
      if (last_tap) n_last++;
      got = {pixel_idx, rom_addr, first_tap, last_tap};
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_underflow got=%h exp=<none>", got);
      end else begin
        exp_e = exp_q.pop_front();
        if (got !== exp_e) $display("FAIL sb_tap got=%h exp=%h", got, exp_e);
        else n_pass++;
      end
    end
    if (rst_n && win_pop) n_pop++;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    for (int p = 0; p < OUT_PIXELS; p++)
      for (int a = 0; a < TAPS; a++)
        exp_q.push_back({PIX_W'(p), ADDR'(a), (a == 0), (a == TAPS - 1)});
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic start_frame();
    push_frame();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; win_valid = 1'b0; tap_ready = 1'b0;
    repeat (3) cyc();
    n_checks++;
    if ({tap_valid, win_pop, first_tap, last_tap} !== 4'b0)
      $display("FAIL reset_strobes got=%b exp=0000", {tap_valid, win_pop, first_tap, last_tap});
    else n_pass++;
    n_checks++;
    if ({busy, done} !== 2'b00) $display("FAIL reset_busy_done got=%b exp=00", {busy, done});
    else n_pass++;
    n_checks++;
    if (rom_addr !== 5'd0 || pixel_idx !== 14'd0)
      $display("FAIL reset_counters got addr=%0d pix=%0d exp=0/0", rom_addr, pixel_idx);
    else n_pass++;
    n_checks++;
    if (fsm_state !== IDLE) $display("FAIL reset_state got=%0d exp=%0d", fsm_state, IDLE);
    else n_pass++;
    rst_n = 1'b1;
    cyc();
  endtask

  // Cycle-exact frame: start in c0, taps c2..c28 and c30..c56, done in c57.
  task automatic test_nominal();
    bit e_tv, e_pop, e_done, e_busy;
    win_valid = 1'b1; tap_ready = 1'b1;
    push_frame();
    start = 1'b1;
    for (int c = 1; c <= 58; c++) begin
      cyc();
      start = 1'b0;
      e_tv   = (c >= 2 && c <= 28) || (c >= 30 && c <= 56);
      e_pop  = (c == 29) || (c == 57);
      e_done = (c == 57);
      e_busy = (c <= 57);
      n_checks++;
      if (tap_valid !== e_tv) $display("FAIL nom_tap_valid c%0d got=%b exp=%b", c, tap_valid, e_tv);
      else n_pass++;
      n_checks++;
      if (win_pop !== e_pop) $display("FAIL nom_win_pop c%0d got=%b exp=%b", c, win_pop, e_pop);
      else n_pass++;
      n_checks++;
      if (done !== e_done) $display("FAIL nom_done c%0d got=%b exp=%b", c, done, e_done);
      else n_pass++;
      n_checks++;
      if (busy !== e_busy) $display("FAIL nom_busy c%0d got=%b exp=%b", c, busy, e_busy);
      else n_pass++;
    end
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL nom_leftover got=%0d exp=0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_stall();
    bit found, seen;
    win_valid = 1'b1; tap_ready = 1'b1;
    start_frame();
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (tap_valid && rom_addr == 5'd13 && pixel_idx == 14'd0) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    n_checks++;
    if (!found) $display("FAIL stall_reach got=timeout exp=addr13");
    else n_pass++;
    tap_ready = 1'b0;
    repeat (5) begin
      cyc();
      n_checks++;
      if (rom_addr !== 5'd13 || tap_valid !== 1'b1)
        $display("FAIL stall_hold got addr=%0d tv=%b exp=13/1", rom_addr, tap_valid);
      else n_pass++;
    end
    tap_ready = 1'b1;
    wait_done(200, seen);
    n_checks++;
    if (!seen) $display("FAIL stall_done got=timeout exp=done");
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL stall_leftover got=%0d exp=0", exp_q.size());
    else n_pass++;
    cyc();
  endtask

  task automatic test_win_gap();
    bit found, seen;
    win_valid = 1'b1; tap_ready = 1'b1;
    start_frame();
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (last_tap && pixel_idx == 14'd0) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    n_checks++;
    if (!found) $display("FAIL gap_reach got=timeout exp=last_tap");
    else n_pass++;
    win_valid = 1'b0;
    cyc();
    n_checks++;
    if (win_pop !== 1'b1) $display("FAIL gap_pop got=%b exp=1", win_pop);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_checks++;
      if (tap_valid !== 1'b0 || pixel_idx !== 14'd1 || fsm_state !== WAIT_WIN)
        $display("FAIL gap_wait got tv=%b pix=%0d st=%0d exp=0/1/%0d",
                 tap_valid, pixel_idx, fsm_state, WAIT_WIN);
      else n_pass++;
    end
    win_valid = 1'b1;
    wait_done(100, seen);
    n_checks++;
    if (!seen) $display("FAIL gap_done got=timeout exp=done");
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL gap_leftover got=%0d exp=0", exp_q.size());
    else n_pass++;
    cyc();
  endtask

  task automatic test_reset_mid();
    bit found, seen;
    logic [EW+7:0] outs;
    win_valid = 1'b1; tap_ready = 1'b1;
    start_frame();
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (tap_valid && rom_addr == 5'd20 && pixel_idx == 14'd1) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    n_checks++;
    if (!found) $display("FAIL rmid_reach got=timeout exp=pix1_addr20");
    else n_pass++;
    rst_n = 1'b0;
    cyc();
    outs = {tap_valid, win_pop, first_tap, last_tap, busy, done, fsm_state, rom_addr, pixel_idx};
    n_checks++;
    if (outs !== '0) $display("FAIL rmid_outputs got=%h exp=0", outs);
    else n_pass++;
    exp_q.delete();
    rst_n = 1'b1;
    cyc();
    n_checks++;
    if (busy !== 1'b0 || fsm_state !== IDLE) $display("FAIL rmid_idle got busy=%b st=%0d exp=0/0", busy, fsm_state);
    else n_pass++;
    start_frame();
    wait_done(100, seen);
    n_checks++;
    if (!seen) $display("FAIL rmid_done got=timeout exp=done");
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL rmid_leftover got=%0d exp=0", exp_q.size());
    else n_pass++;
    cyc();
  endtask

  task automatic test_start_ignored();
    int n_done;
    win_valid = 1'b1; tap_ready = 1'b1;
    start_frame();
    n_done = 0;
    for (int i = 0; i < 120; i++) begin
      if (done) n_done++;
      // Pulse start mid-stream and during the DONE cycle.
      start = (tap_valid && (rom_addr == 5'd5 || rom_addr == 5'd26)) || done;
      cyc();
    end
    start = 1'b0;
    n_checks++;
    if (n_done != 1) $display("FAIL sti_done_count got=%0d exp=1", n_done);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || fsm_state !== IDLE) $display("FAIL sti_idle got busy=%b st=%0d exp=0/0", busy, fsm_state);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL sti_leftover got=%0d exp=0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_random();
    localparam int FRAMES = 6;
    bit seen;
    n_acc = 0; n_first = 0; n_last = 0; n_pop = 0;
    for (int f = 0; f < FRAMES; f++) begin
      start_frame();
      seen = 1'b0;
      for (int i = 0; i < 2000; i++) begin
        win_valid = ($urandom_range(0, 3) != 0);
        tap_ready = ($urandom_range(0, 2) != 0);
        cyc();
        if (done) begin
          seen = 1'b1;
          break;
        end
      end
      n_checks++;
      if (!seen) $display("FAIL rnd_done f%0d got=timeout exp=done", f);
      else n_pass++;
      cyc();
    end
    win_valid = 1'b1; tap_ready = 1'b1;
    n_checks++;
    if (n_acc != FRAMES * OUT_PIXELS * TAPS) $display("FAIL rnd_accepts got=%0d exp=%0d", n_acc, FRAMES * OUT_PIXELS * TAPS);
    else n_pass++;
    n_checks++;
    if (n_first != FRAMES * OUT_PIXELS) $display("FAIL rnd_first got=%0d exp=%0d", n_first, FRAMES * OUT_PIXELS);
    else n_pass++;
    n_checks++;
    if (n_last != FRAMES * OUT_PIXELS) $display("FAIL rnd_last got=%0d exp=%0d", n_last, FRAMES * OUT_PIXELS);
    else n_pass++;
    n_checks++;
    if (n_pop != FRAMES * OUT_PIXELS) $display("FAIL rnd_pops got=%0d exp=%0d", n_pop, FRAMES * OUT_PIXELS);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL rnd_leftover got=%0d exp=0", exp_q.size());
    else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; win_valid = 1'b0; tap_ready = 1'b0;
    test_reset();
    test_nominal();
    test_stall();
    test_win_gap();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
